// File: rtl/line_adaptor_pkg.sv
// Shared constants and FSM state type for the cacheline-to-memory burst adaptor.
package line_adaptor_pkg;

  localparam int LINE_BEATS       = 4;
  localparam int BEAT_W           = 64;
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_BURST = 3'd1,
    ST_RD_DONE  = 3'd2,
    ST_WR_BURST = 3'd3,
    ST_WR_DONE  = 3'd4
  } line_adaptor_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Line staging register: full-line load (write capture), per-beat write (read fill), per-beat read mux (write drain).
// Updates on the next edge; no handshake, the owner sequences the enables.
module line_beat_buffer
  import line_adaptor_pkg::*;
#(
  parameter int BEATS = LINE_BEATS,
  parameter int WIDTH = BEAT_W,
  parameter int IDX_W = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [BEATS*WIDTH-1:0] load_line,
  input  logic                   beat_we,
  input  logic [IDX_W-1:0]       beat_idx,
  input  logic [WIDTH-1:0]       beat_wdata,
  output logic [WIDTH-1:0]       beat_rdata,
  output logic [BEATS*WIDTH-1:0] line
);

  logic [BEATS*WIDTH-1:0] line_q;
  logic [BEATS*WIDTH-1:0] line_d;

  // A full-line load takes priority; both are never requested together by the FSM.
  always_comb begin
    line_d = line_q;
    if (load_en) begin
      line_d = load_line;
    end else if (beat_we) begin
      line_d[int'(beat_idx)*WIDTH +: WIDTH] = beat_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign beat_rdata = line_q[int'(beat_idx)*WIDTH +: WIDTH];
  assign line       = line_q;

endmodule

// File: rtl/line_burst_adaptor.sv
// Cacheline port responder: one line read/write-back done as a 4-beat memory burst; response 1 cycle after the last ack
// (LINE_ADAPTOR_WRITE_POST_EN: write response in cycle 1, burst drains in background). Ack gaps stall the beat counter.
module line_burst_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       line_addr_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              line_read_i,
  input  logic              line_write_i,
  output logic [LINE_W-1:0] line_o,
  output logic              line_resp_o,
  output logic [31:0]       mem_addr_o,
  output logic [BEAT_W-1:0] mem_wdata_o,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic              mem_resp_i
);
  import line_adaptor_pkg::*;

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  line_adaptor_state_t state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic                load_en;
  logic                beat_we;
  logic [BEAT_W-1:0]   beat_rdata;
  logic [LINE_W-1:0]   buf_line;
  logic                unused_addr_bits;

`ifdef LINE_ADAPTOR_WRITE_POST_EN
  logic wr_first_q, wr_first_d;
`endif

  assign unused_addr_bits = ^line_addr_i[LINE_OFFSET_BITS-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    load_en = 1'b0;
    beat_we = 1'b0;
`ifdef LINE_ADAPTOR_WRITE_POST_EN
    wr_first_d = 1'b0;
`endif
    case (state_q)
      // Write wins a tie: the dirty victim leaves before the fill arrives.
      ST_IDLE: begin
        if (line_write_i) begin
          addr_d  = {line_addr_i[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          cnt_d   = '0;
          load_en = 1'b1;
          state_d = ST_WR_BURST;
`ifdef LINE_ADAPTOR_WRITE_POST_EN
          wr_first_d = 1'b1;
`endif
        end else if (line_read_i) begin
          addr_d  = {line_addr_i[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          cnt_d   = '0;
          state_d = ST_RD_BURST;
        end
      end
      ST_RD_BURST: begin
        if (mem_resp_i) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_RD_DONE;
          end
        end
      end
      ST_RD_DONE: state_d = ST_IDLE;
      ST_WR_BURST: begin
        if (mem_resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
`ifdef LINE_ADAPTOR_WRITE_POST_EN
            state_d = ST_IDLE;
`else
            state_d = ST_WR_DONE;
`endif
          end
        end
      end
      ST_WR_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

`ifdef LINE_ADAPTOR_WRITE_POST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_first_q <= 1'b0;
    end else begin
      wr_first_q <= wr_first_d;
    end
  end
`endif

  line_beat_buffer #(
    .BEATS (BEATS),
    .WIDTH (BEAT_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_line  (line_i),
    .beat_we    (beat_we),
    .beat_idx   (cnt_q),
    .beat_wdata (mem_rdata_i),
    .beat_rdata (beat_rdata),
    .line       (buf_line)
  );

  assign mem_read_o  = (state_q == ST_RD_BURST);
  assign mem_write_o = (state_q == ST_WR_BURST);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = mem_write_o ? beat_rdata : '0;
  assign line_o      = (state_q == ST_RD_DONE) ? buf_line : '0;

`ifdef LINE_ADAPTOR_WRITE_POST_EN
  assign line_resp_o = (state_q == ST_RD_DONE) || ((state_q == ST_WR_BURST) && wr_first_q);
`else
  assign line_resp_o = (state_q == ST_RD_DONE) || (state_q == ST_WR_DONE);
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed plus randomized bench for line_burst_adaptor with a line-level memory model.
module tb_line_burst_adaptor;

`ifdef LINE_ADAPTOR_WRITE_POST_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_addr_i;
  logic [255:0] line_i;
  logic         line_read_i;
  logic         line_write_i;
  logic [255:0] line_o;
  logic         line_resp_o;
  logic [31:0]  mem_addr_o;
  logic [63:0]  mem_wdata_o;
  logic [63:0]  mem_rdata_i;
  logic         mem_read_o;
  logic         mem_write_o;
  logic         mem_resp_i;

  int n_chk = 0;
  int n_err = 0;
  logic [255:0] mem_model [logic [31:0]];

  line_burst_adaptor #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .line_addr_i  (line_addr_i),
    .line_i       (line_i),
    .line_read_i  (line_read_i),
    .line_write_i (line_write_i),
    .line_o       (line_o),
    .line_resp_o  (line_resp_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_resp_i   (mem_resp_i)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_line_o"}, line_o, '0);
    check({tag, "_resp"}, line_resp_o, '0);
    check({tag, "_addr"}, mem_addr_o, '0);
    check({tag, "_wdata"}, mem_wdata_o, '0);
    check({tag, "_rd"}, mem_read_o, '0);
    check({tag, "_wr"}, mem_write_o, '0);
  endtask

  // Read fill: request starts in the current (IDLE) cycle; beat i arrives after gap[i] idle cycles.
  task automatic do_read(input logic [31:0] a, input logic [63:0] b [4], input int gap [4]);
    logic [31:0]  ea;
    logic [255:0] exp_line;
    ea       = {a[31:5], 5'b0};
    exp_line = {b[3], b[2], b[1], b[0]};
    line_addr_i = a;
    line_read_i = 1'b1;
    tick();
    line_addr_i = $urandom;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g <= gap[i]; g++) begin
        mem_resp_i  = (g == gap[i]);
        mem_rdata_i = (g == gap[i]) ? b[i] : {$urandom, $urandom};
        @(negedge clk);
        check("rd_strobe", mem_read_o, 1'b1);
        check("rd_no_wr", mem_write_o, 1'b0);
        check("rd_addr", mem_addr_o, ea);
        check("rd_resp_early", line_resp_o, 1'b0);
        tick();
      end
    end
    mem_resp_i  = 1'b1;
    mem_rdata_i = {$urandom, $urandom};
    @(negedge clk);
    check("rd_resp", line_resp_o, 1'b1);
    check("rd_line", line_o, exp_line);
    check("rd_done_strobe", mem_read_o, 1'b0);
    tick();
    mem_resp_i  = 1'b0;
    line_read_i = 1'b0;
    @(negedge clk);
    check("rd_resp_once", line_resp_o, 1'b0);
    check("rd_line_idle", line_o, '0);
    check("rd_idle_strobe", mem_read_o, 1'b0);
  endtask

  // Write-back: beat data must follow ack count, not time.
  task automatic do_write(input logic [31:0] a, input logic [255:0] ln, input int gap [4]);
    logic [31:0] ea;
    int c;
    int tail;
    ea = {a[31:5], 5'b0};
    line_addr_i  = a;
    line_i       = ln;
    line_write_i = 1'b1;
    tick();
    line_addr_i = $urandom;
    line_i      = {8{$urandom}};
    c = 1;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g <= gap[i]; g++) begin
        mem_resp_i  = (g == gap[i]);
        mem_rdata_i = {$urandom, $urandom};
        @(negedge clk);
        check("wr_strobe", mem_write_o, 1'b1);
        check("wr_no_rd", mem_read_o, 1'b0);
        check("wr_addr", mem_addr_o, ea);
        check("wr_data", mem_wdata_o, ln[i*64 +: 64]);
        check("wr_resp", line_resp_o, POSTED && (c == 1));
        tick();
        c++;
        if (POSTED) line_write_i = 1'b0;
      end
    end
    mem_resp_i = 1'b1;
    mem_model[ea] = ln;
    tail = POSTED ? 1 : 2;
    for (int t = 0; t < tail; t++) begin
      if (t == tail - 1) line_write_i = 1'b0;
      @(negedge clk);
      check("wr_tail_resp", line_resp_o, !POSTED && (t == 0));
      check("wr_tail_strobe", mem_write_o, 1'b0);
      check("wr_tail_rd", mem_read_o, 1'b0);
      if (t < tail - 1) tick();
    end
    mem_resp_i = 1'b0;
  endtask

  initial begin
    logic [63:0]  b [4];
    int           gp [4];
    logic [31:0]  a;
    logic [255:0] ln;

    rst = 1'b0;
    line_addr_i = '0; line_i = '0; line_read_i = 1'b0; line_write_i = 1'b0;
    mem_rdata_i = '0; mem_resp_i = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_all_zero("post_reset_idle");

    // Directed read fill, back-to-back acks.
    b  = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    gp = '{0, 0, 0, 0};
    do_read(32'h0000_1234, b, gp);

    // Directed write-back with ack gaps 0, 2, 1 between beats.
    ln = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    gp = '{0, 0, 2, 1};
    do_write(32'h0000_2040, ln, gp);

    // Simultaneous read and write: write burst first, then the still-held read.
    line_read_i = 1'b1;
    gp = '{1, 0, 0, 0};
    do_write(32'h0000_3000, {8{32'h5A5A_0F0F}}, gp);
    b  = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
           64'h0F0F_0F0F_F0F0_F0F0, 64'h8000_0000_0000_0001};
    gp = '{0, 1, 0, 2};
    do_read(32'h0000_401F, b, gp);

    // Reset in the middle of a read after two beats.
    line_addr_i = 32'h0000_8040;
    line_read_i = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      mem_resp_i  = 1'b1;
      mem_rdata_i = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      tick();
    end
    mem_resp_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    line_read_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midreset_no_resp", line_resp_o, 1'b0);
    check("midreset_idle_rd", mem_read_o, 1'b0);
    b  = '{64'h0000_0000_0000_00A1, 64'h0000_0000_0000_00B2,
           64'h0000_0000_0000_00C3, 64'h0000_0000_0000_00D4};
    gp = '{0, 0, 1, 0};
    do_read(32'h0000_8040, b, gp);

    // Randomized mix of write-backs and fills over a small set of lines.
    for (int n = 0; n < 12; n++) begin
      a = 32'h0001_0000 + (32'($urandom_range(0, 3)) << 5) + 32'($urandom_range(0, 31));
      for (int i = 0; i < 4; i++) gp[i] = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        ln = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_write(a, ln, gp);
      end else begin
        if (mem_model.exists({a[31:5], 5'b0})) ln = mem_model[{a[31:5], 5'b0}];
        else ln = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) b[i] = ln[i*64 +: 64];
        do_read(a, b, gp);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
